// File: rtl/gtype.sv
// Shared XGMII types, control characters, error-bit positions and parser states
// for the 64-bit XGMII receive-side checker.
package gtype;

    localparam int unsigned XGMII_LANES = 8;
    localparam int unsigned ERR_W       = 6;
    localparam int unsigned LEN_W       = 14;

    typedef struct packed {
        logic       ena;
        logic [7:0] ctrl;
        logic [63:0] data;
    } xgmii64_t;

    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;
    localparam logic [7:0] XGMII_PRE   = 8'h55;
    localparam logic [7:0] XGMII_SFD   = 8'hD5;

    localparam int unsigned ERR_PRE   = 0;
    localparam int unsigned ERR_PAT   = 1;
    localparam int unsigned ERR_CTRL  = 2;
    localparam int unsigned ERR_START = 3;
    localparam int unsigned ERR_LEN   = 4;
    localparam int unsigned ERR_ABORT = 5;

    typedef logic [1:0] rx_state_t;
    localparam rx_state_t ST_IDLE = 2'd0;
    localparam rx_state_t ST_PRE  = 2'd1;
    localparam rx_state_t ST_PAY  = 2'd2;

endpackage

// File: rtl/xgmii_sat_cnt.sv
// Saturating event counter with synchronous clear taking priority over increment.
module xgmii_sat_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/xgmii_rx_checker.sv
// Sink-side XGMII frame checker: parses /S/, preamble, incrementing payload and /T/
// across 8 lanes per word, reports per-frame status and keeps saturating statistics.
module xgmii_rx_checker
    import gtype::*;
#(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_156,
    input  logic             rst_156_n,
    input  xgmii64_t         xgmii_rx,
    input  logic             xgmii_rx_rdy,
    input  logic             clr,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [ERR_W-1:0] frame_err,
    output logic [LEN_W-1:0] frame_len,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             in_frame
);

    localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    rx_state_t        state_q, state_d;
    logic [2:0]       pre_cnt_q, pre_cnt_d;
    logic [7:0]       exp_q, exp_d;
    logic             first_q, first_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             done_d;
    logic             stop;
    logic [7:0]       byte_v;
    logic             ctrl_v;

    // Lanes 0..7 walked in order; each lane sees the state left by the previous one.
    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        exp_d     = exp_q;
        first_d   = first_q;
        err_d     = err_q;
        len_d     = len_q;
        done_d    = 1'b0;
        stop      = 1'b0;
        byte_v    = 8'h00;
        ctrl_v    = 1'b0;
        if (!xgmii_rx_rdy) begin
            if (state_q != ST_IDLE) begin
                err_d[ERR_ABORT] = 1'b1;
                done_d           = 1'b1;
                state_d          = ST_IDLE;
            end
        end else if (xgmii_rx.ena) begin
            for (int k = 0; k < XGMII_LANES; k++) begin
                byte_v = xgmii_rx.data[k*8 +: 8];
                ctrl_v = xgmii_rx.ctrl[k];
                if (!stop) begin
                    case (state_d)
                        ST_IDLE: begin
                            if (ctrl_v && (byte_v == XGMII_START) && ((k == 0) || (k == 4))) begin
                                state_d   = ST_PRE;
                                pre_cnt_d = 3'd0;
                                first_d   = 1'b1;
                                err_d     = '0;
                                len_d     = '0;
                            end
                        end
                        ST_PRE: begin
                            if (ctrl_v && (byte_v == XGMII_START)) begin
                                err_d[ERR_START] = 1'b1;
                                done_d           = 1'b1;
                                stop             = 1'b1;
                                state_d          = ST_IDLE;
                            end else if (ctrl_v && (byte_v == XGMII_TERM)) begin
                                // Terminate inside the preamble still closes the frame
                                err_d[ERR_PRE] = 1'b1;
                                err_d[ERR_LEN] = 1'b1;
                                done_d         = 1'b1;
                                stop           = 1'b1;
                                state_d        = ST_IDLE;
                            end else begin
                                if (ctrl_v || (byte_v != ((pre_cnt_d == 3'd6) ? XGMII_SFD : XGMII_PRE))) begin
                                    err_d[ERR_PRE] = 1'b1;
                                end
                                if (pre_cnt_d == 3'd6) begin
                                    state_d = ST_PAY;
                                end else begin
                                    pre_cnt_d = pre_cnt_d + 3'd1;
                                end
                            end
                        end
                        ST_PAY: begin
                            if (ctrl_v && (byte_v == XGMII_TERM)) begin
                                if ((len_d < MIN_L) || (len_d > MAX_L)) begin
                                    err_d[ERR_LEN] = 1'b1;
                                end
                                done_d  = 1'b1;
                                stop    = 1'b1;
                                state_d = ST_IDLE;
                            end else if (ctrl_v && (byte_v == XGMII_START)) begin
                                err_d[ERR_START] = 1'b1;
                                done_d           = 1'b1;
                                stop             = 1'b1;
                                state_d          = ST_IDLE;
                            end else if (ctrl_v) begin
                                err_d[ERR_CTRL] = 1'b1;
                            end else begin
                                if (!first_d && (byte_v != exp_d)) begin
                                    err_d[ERR_PAT] = 1'b1;
                                end
                                first_d = 1'b0;
                                exp_d   = byte_v + 8'd1;
                                if (len_d != '1) begin
                                    len_d = len_d + LEN_W'(1);
                                end
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_156 or negedge rst_156_n) begin
        if (!rst_156_n) begin
            state_q    <= ST_IDLE;
            pre_cnt_q  <= 3'd0;
            exp_q      <= 8'h00;
            first_q    <= 1'b0;
            err_q      <= '0;
            len_q      <= '0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= '0;
            frame_len  <= '0;
            in_frame   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            exp_q      <= exp_d;
            first_q    <= first_d;
            err_q      <= err_d;
            len_q      <= len_d;
            frame_done <= done_d;
            in_frame   <= (state_d != ST_IDLE);
            if (done_d) begin
                frame_ok  <= (err_d == '0);
                frame_err <= err_d;
                frame_len <= len_d;
            end
        end
    end

    xgmii_sat_cnt #(.CNT_W(CNT_W)) u_ok_cnt (
        .clk   (clk_156),
        .rst_n (rst_156_n),
        .inc   (frame_done & frame_ok),
        .clr   (clr),
        .cnt   (ok_cnt)
    );

    xgmii_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk_156),
        .rst_n (rst_156_n),
        .inc   (frame_done & ~frame_ok),
        .clr   (clr),
        .cnt   (err_cnt)
    );

endmodule
